vga_vram_server: RTL and testbench

VGA_VRAM_SERVER -- requirements
Module: vga_vram_server

---
 rtl/vga_vram_server_pkg.sv | 19 +
 rtl/vga_vram_wfifo.sv | 54 +++++
 rtl/vga_vram_server.sv | 133 +++++++++++++
 tb/tb_vga_vram_server.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_vram_server_pkg.sv
// Shared VRAM constants, server state encoding and FIFO sizing helper.
package vga_vram_server_pkg;

    localparam int VRAM_PWIDTH  = 8;
    localparam int VRAM_AWIDTH  = 19;
    localparam int VRAM_LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_FORCE = 2'd2
    } srv_state_t;

    // Pointer width for a power-of-2 FIFO: index bits plus one wrap bit.
    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vga_vram_wfifo.sv
// Write-buffer FIFO for core writes; wrap-bit pointers, push+pop legal when full.
module vga_vram_wfifo
    import vga_vram_server_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = fifo_ptr_w(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // When full, a push only lands if the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[IDX_W-1:0]];

    // Advance pointers; reset empties the FIFO without touching storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Store accepted entries.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[IDX_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/vga_vram_server.sv
// VRAM responder: serves VGA pixel reads and buffered core writes on one memory port.
module vga_vram_server
    import vga_vram_server_pkg::*;
#(
    parameter int PWIDTH  = VRAM_PWIDTH,
    parameter int AWIDTH  = VRAM_AWIDTH,
    parameter int LATENCY = VRAM_LATENCY,
    parameter int WDEPTH  = 4,
    parameter int STARVE  = 16
) (
    input  logic              clk_core,
    input  logic              rst_core,
    output logic              vram_busy,
    input  logic              vram_rd,
    input  logic [AWIDTH-1:0] vram_addr,
    output logic [PWIDTH-1:0] vram_data,
    output logic              vram_vld,
    input  logic              wr_req,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [PWIDTH-1:0] wr_data,
    output logic              wr_ready,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [PWIDTH-1:0] mem_wdata,
    input  logic [PWIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(WDEPTH) + 1;
    localparam int STV_W = $clog2(STARVE) + 1;
    localparam int ENT_W = AWIDTH + PWIDTH;

    srv_state_t        state;
    srv_state_t        state_next;
    logic [ENT_W-1:0]  head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              force_slot;
    logic              rd_accept;
    logic              fifo_wr;
    logic              blocked;
    logic              force_req;
    logic              inflight_next;
    logic [STV_W-1:0]  starve_cnt;
    logic [LATENCY-1:0] vld_p;
    logic [PWIDTH-1:0] data_p [1:LATENCY-1];

    vga_vram_wfifo #(
        .WIDTH (ENT_W),
        .DEPTH (WDEPTH)
    ) u_wfifo (
        .clk       (clk_core),
        .rst_n     (rst_core),
        .push      (push),
        .push_data ({wr_addr, wr_data}),
        .pop       (fifo_wr),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Slot arbitration (forced write > read > FIFO write), outputs and next state.
    always_comb begin
        force_slot    = (state == ST_FORCE);
        rd_accept     = 1'b0;
        fifo_wr       = 1'b0;
        state_next    = state;
        if (rst_core) begin
            rd_accept = vram_rd & ~force_slot;
            fifo_wr   = ~fifo_empty & (force_slot | ~vram_rd);
        end
        // The forced slot always pops, so the freed entry can take a write that same cycle.
        wr_ready      = ~rst_core | ~fifo_full | force_slot;
        push          = wr_req & wr_ready;
        blocked       = ~fifo_empty & ~fifo_wr;
        force_req     = blocked && (starve_cnt == STV_W'(STARVE - 1));
        count_next    = fifo_count + CNT_W'(push) - CNT_W'(fifo_wr);
        inflight_next = rd_accept | (|vld_p[LATENCY-2:0]);

        vram_busy = rst_core & force_slot;
        mem_re    = rd_accept;
        mem_we    = fifo_wr;
        mem_addr  = fifo_wr ? head[ENT_W-1:PWIDTH] : vram_addr;
        mem_wdata = fifo_wr ? head[PWIDTH-1:0] : '0;
        vram_vld  = rst_core & vld_p[LATENCY-1];
        vram_data = vram_vld ? data_p[LATENCY-1] : '0;

        case (state)
            ST_FORCE: state_next = ST_SERVE;
            default: begin
                if (force_req)
                    state_next = ST_FORCE;
                else if ((count_next == '0) && !inflight_next)
                    state_next = ST_IDLE;
                else
                    state_next = ST_SERVE;
            end
        endcase
    end

    // State register and starvation counter.
    always_ff @(posedge clk_core) begin
        if (!rst_core) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
        end else begin
            state <= state_next;
            if (fifo_empty || fifo_wr)
                starve_cnt <= '0;
            else
                starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    // p0: issue flag; p1..p(LATENCY-1): valid follows the memory data down the pipe.
    always_ff @(posedge clk_core) begin
        if (!rst_core)
            vld_p <= '0;
        else
            vld_p <= {vld_p[LATENCY-2:0], rd_accept};
    end

    // p1 captures mem_rdata one cycle after issue; later stages only delay it.
    always_ff @(posedge clk_core) begin
        if (vld_p[0]) data_p[1] <= mem_rdata;
        for (int i = 2; i < LATENCY; i++) data_p[i] <= data_p[i-1];
    end

endmodule

// File: tb/tb_vga_vram_server.sv
// Directed bench for vga_vram_server with queue-based read/write scoreboards.
module tb_vga_vram_server;

    localparam int PW  = 8;
    localparam int AW  = 19;
    localparam int LAT = 4;

    logic          clk_core = 1'b0;
    logic          rst_core;
    logic          vram_busy;
    logic          vram_rd;
    logic [AW-1:0] vram_addr;
    logic [PW-1:0] vram_data;
    logic          vram_vld;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [PW-1:0] mem_wdata;
    logic [PW-1:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct { int cyc; logic [PW-1:0] data; } rd_exp_t;
    typedef struct { int cyc; logic [AW-1:0] addr; logic [PW-1:0] data; } wr_exp_t;
    rd_exp_t rq[$];
    wr_exp_t wq[$];

    logic [PW-1:0] shadow [0:255];
    logic [PW-1:0] mem    [0:255];
    logic          init_done = 1'b0;

    vga_vram_server dut (
        .clk_core  (clk_core),
        .rst_core  (rst_core),
        .vram_busy (vram_busy),
        .vram_rd   (vram_rd),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .vram_vld  (vram_vld),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk_core = ~clk_core;

    always @(posedge clk_core) cyc <= cyc + 1;

    function automatic logic [PW-1:0] pat(input int a);
        if (a == 16) return 8'hA5;
        return 8'(a * 7 + 3);
    endfunction

    // Single-port synchronous memory: read data valid the cycle after mem_re.
    always @(posedge clk_core) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            init_done <= 1'b1;
        end
        if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    // Monitor: pops expectations whenever the DUT presents a read result or memory write.
    always @(negedge clk_core) begin
        rd_exp_t re;
        wr_exp_t we;
        tests++;
        if (mem_re && mem_we) begin
            fails++;
            $display("FAIL mem_exclusive cycle %0d: mem_re=%0b mem_we=%0b, required not both", cyc, mem_re, mem_we);
        end
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
            re = rq.pop_front();
            tests++; fails++;
            $display("FAIL vld_missing cycle %0d: no vram_vld, required one with data %0h", re.cyc, re.data);
        end
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
            we = wq.pop_front();
            tests++; fails++;
            $display("FAIL we_missing cycle %0d: no mem_we, required addr %0h data %0h", we.cyc, we.addr, we.data);
        end
        if (vram_vld) begin
            tests++;
            if (rq.size() == 0) begin
                fails++;
                $display("FAIL vld_unexpected cycle %0d: vram_vld=1 data %0h, required no vld", cyc, vram_data);
            end else begin
                re = rq.pop_front();
                if (re.cyc != cyc || re.data !== vram_data) begin
                    fails++;
                    $display("FAIL vld_data: got data %0h at cycle %0d, required %0h at cycle %0d", vram_data, cyc, re.data, re.cyc);
                end
            end
        end
        if (mem_we) begin
            tests++;
            if (wq.size() == 0) begin
                fails++;
                $display("FAIL we_unexpected cycle %0d: mem_we addr %0h data %0h, required no write", cyc, mem_addr, mem_wdata);
            end else begin
                we = wq.pop_front();
                if (we.cyc != cyc || we.addr !== mem_addr || we.data !== mem_wdata) begin
                    fails++;
                    $display("FAIL we_data: got %0h/%0h at cycle %0d, required %0h/%0h at cycle %0d", mem_addr, mem_wdata, cyc, we.addr, we.data, we.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk_core);
        #1;
    endtask

    task automatic exp_read(input int a);
        rd_exp_t e;
        e.cyc  = cyc + LAT;
        e.data = shadow[a];
        rq.push_back(e);
    endtask

    task automatic exp_write(input int c, input int a, input int d);
        wr_exp_t e;
        e.cyc  = c;
        e.addr = AW'(a);
        e.data = PW'(d);
        wq.push_back(e);
    endtask

    task automatic idle(input int n);
        vram_rd = 1'b0;
        wr_req  = 1'b0;
        repeat (n) next();
    endtask

    task automatic read_one(input int a);
        vram_rd   = 1'b1;
        vram_addr = AW'(a);
        exp_read(a);
        next();
        idle(LAT + 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int p;
        for (int i = 0; i < 256; i++) shadow[i] = pat(i);
        rst_core  = 1'b0;
        vram_rd   = 1'b1;
        vram_addr = AW'(5);
        wr_req    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        next();

        // Reset: outputs quiet even with a read request pending.
        repeat (2) begin
            @(negedge clk_core);
            chk("rst_vram_vld", vram_vld, 0);
            chk("rst_mem_re", mem_re, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_vram_busy", vram_busy, 0);
            chk("rst_wr_ready", wr_ready, 1);
            chk("rst_vram_data", vram_data, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            next();
        end
        rst_core = 1'b1;
        vram_rd  = 1'b0;
        next();
        @(negedge clk_core);
        chk("post_rst_busy", vram_busy, 0);
        chk("post_rst_wr_ready", wr_ready, 1);
        next();

        // Single read latency.
        read_one(16);

        // Eight back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            vram_rd   = 1'b1;
            vram_addr = AW'(i);
            exp_read(i);
            @(negedge clk_core);
            chk("b2b_busy", vram_busy, 0);
            next();
        end
        idle(LAT + 2);

        // Write while idle lands one cycle later; read it back.
        wr_req  = 1'b1;
        wr_addr = AW'(32);
        wr_data = 8'h3C;
        exp_write(cyc + 1, 32, 8'h3C);
        @(negedge clk_core);
        chk("idle_wr_ready", wr_ready, 1);
        next();
        wr_req = 1'b0;
        next();
        shadow[32] = 8'h3C;
        read_one(32);

        // Starvation: one buffered write under continuous reads.
        p = cyc;
        exp_write(p + 17, 8'h30, 8'h77);
        for (int k = 0; k < 20; k++) begin
            vram_rd   = 1'b1;
            vram_addr = AW'((k == 16) ? 8'h30 : 8'h40 + k);
            wr_req    = (k == 0);
            wr_addr   = AW'(8'h30);
            wr_data   = 8'h77;
            if (k != 17) exp_read((k == 16) ? 8'h30 : 8'h40 + k);
            @(negedge clk_core);
            chk("starve_busy", vram_busy, (k == 17));
            next();
        end
        idle(LAT + 2);
        shadow[8'h30] = 8'h77;
        read_one(8'h30);

        // Full FIFO: four writes, fifth stalls until the forced slot frees an entry.
        p = cyc;
        exp_write(p + 17, 8'h60, 8'h90);
        exp_write(p + 19, 8'h61, 8'h91);
        exp_write(p + 20, 8'h62, 8'h92);
        exp_write(p + 21, 8'h63, 8'h93);
        exp_write(p + 22, 8'h64, 8'h94);
        for (int k = 0; k < 23; k++) begin
            vram_rd   = (k <= 18);
            vram_addr = AW'(8'h50 + k);
            wr_req    = (k <= 17);
            wr_addr   = AW'((k < 4) ? 8'h60 + k : 8'h64);
            wr_data   = PW'((k < 4) ? 8'h90 + k : 8'h94);
            if (k <= 18 && k != 17) exp_read(8'h50 + k);
            @(negedge clk_core);
            chk("full_wr_ready", wr_ready, (k < 4) || (k == 17) || (k >= 20));
            chk("full_busy", vram_busy, (k == 17));
            next();
        end
        idle(LAT + 2);

        // Reset mid-stream: reads in flight and writes buffered are discarded.
        for (int k = 0; k < 4; k++) begin
            vram_rd   = 1'b1;
            vram_addr = AW'(8'h70 + k);
            wr_req    = (k < 3);
            wr_addr   = AW'(8'h78 + k);
            wr_data   = PW'(8'hC0 + k);
            next();
        end
        vram_rd  = 1'b0;
        wr_req   = 1'b0;
        rst_core = 1'b0;
        repeat (2) begin
            @(negedge clk_core);
            chk("midrst_wr_ready", wr_ready, 1);
            next();
        end
        rst_core = 1'b1;
        repeat (8) begin
            @(negedge clk_core);
            chk("after_rst_wr_ready", wr_ready, 1);
            chk("after_rst_busy", vram_busy, 0);
            next();
        end

        idle(4);
        chk("rd_queue_drained", rq.size(), 0);
        chk("wr_queue_drained", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
